// File: rtl/round_arb_if.sv
// Requester/result bundle for round_arb: two operand requesters in, one
// rounded, renormalized result out, each side with a valid/ready handshake.
interface round_arb_if #(
    parameter int DATA_W = 24,
    parameter int EXP_W  = 8
);
    logic [1:0]                req_valid;
    logic [1:0]                req_ready;
    logic [2*EXP_W-1:0]        req_exp;
    logic [2*(DATA_W+3)-1:0]   req_mant;
    logic                      out_valid;
    logic                      out_ready;
    logic [EXP_W-1:0]          out_exp;
    logic [DATA_W-1:0]         out_mant;
    logic                      out_tag;

    modport slave (
        input  req_valid, req_exp, req_mant, out_ready,
        output req_ready, out_valid, out_exp, out_mant, out_tag
    );

    modport master (
        output req_valid, req_exp, req_mant, out_ready,
        input  req_ready, out_valid, out_exp, out_mant, out_tag
    );
endinterface

// File: rtl/round_arb.sv
// Round-robin arbiter feeding a two-stage round-to-nearest-even and
// renormalize pipeline; one result per cycle when downstream keeps up.
module round_arb #(
    parameter int DATA_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    round_arb_if.slave bus
);
    localparam int MW   = DATA_W + 3;
    localparam int LZ_W = $clog2(DATA_W + 1);

    logic              lastGrant_q, lastGrant_d;
    logic              s1Valid_q, s1Valid_d;
    logic [EXP_W-1:0]  s1Exp_q, s1Exp_d;
    logic [MW-1:0]     s1Mant_q, s1Mant_d;
    logic              s1Tag_q, s1Tag_d;
    logic              outValid_q, outValid_d;
    logic [EXP_W-1:0]  outExp_q, outExp_d;
    logic [DATA_W-1:0] outMant_q, outMant_d;
    logic              outTag_q, outTag_d;

    logic              grant;
    logic [1:0]        reqReady;
    logic              accept;
    logic              adv1;
    logic              adv2;
    logic              roundUp;
    logic [DATA_W:0]   m;
    logic [LZ_W-1:0]   lz;
    logic              found;
    logic [EXP_W-1:0]  rndExp;
    logic [DATA_W-1:0] rndMant;

    assign adv2   = ~outValid_q | bus.out_ready;
    assign adv1   = ~s1Valid_q | adv2;
    assign accept = |reqReady;

    // On a tie the requester that did not win the last accepted transfer goes next.
    always_comb begin
        grant = 1'b0;
        unique case (bus.req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~lastGrant_q;
            default: grant = 1'b0;
        endcase
    end

    always_comb begin
        reqReady = 2'b00;
        if (rst_n && adv1 && bus.req_valid[grant]) begin
            reqReady[grant] = 1'b1;
        end
    end

    assign bus.req_ready = reqReady;

    always_comb begin
        roundUp = s1Mant_q[2] & (s1Mant_q[1] | s1Mant_q[0] | s1Mant_q[3]);
        m       = {1'b0, s1Mant_q[MW-1:3]} + {{DATA_W{1'b0}}, roundUp};
    end

    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) begin
                    found = 1'b1;
                end else begin
                    lz = lz + LZ_W'(1);
                end
            end
        end
    end

    // Carry out means the mantissa was all ones and rounded up to the next power of two.
    always_comb begin
        rndExp  = '0;
        rndMant = '0;
        if (m[DATA_W]) begin
            rndExp  = s1Exp_q + EXP_W'(1);
            rndMant = {1'b1, {(DATA_W-1){1'b0}}};
        end else if (m[DATA_W-1:0] != '0) begin
            rndExp  = s1Exp_q - EXP_W'(lz);
            rndMant = m[DATA_W-1:0] << lz;
        end
    end

    always_comb begin
        lastGrant_d = lastGrant_q;
        s1Valid_d   = s1Valid_q;
        s1Exp_d     = s1Exp_q;
        s1Mant_d    = s1Mant_q;
        s1Tag_d     = s1Tag_q;
        outValid_d  = outValid_q;
        outExp_d    = outExp_q;
        outMant_d   = outMant_q;
        outTag_d    = outTag_q;

        if (adv1) begin
            s1Valid_d = accept;
        end
        if (accept) begin
            lastGrant_d = grant;
            s1Exp_d     = bus.req_exp[int'(grant)*EXP_W +: EXP_W];
            s1Mant_d    = bus.req_mant[int'(grant)*MW +: MW];
            s1Tag_d     = grant;
        end

        if (adv2) begin
            outValid_d = s1Valid_q;
        end
        if (s1Valid_q && adv2) begin
            outExp_d  = rndExp;
            outMant_d = rndMant;
            outTag_d  = s1Tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant_q <= 1'b1;
            s1Valid_q   <= 1'b0;
            s1Exp_q     <= '0;
            s1Mant_q    <= '0;
            s1Tag_q     <= 1'b0;
            outValid_q  <= 1'b0;
            outExp_q    <= '0;
            outMant_q   <= '0;
            outTag_q    <= 1'b0;
        end else begin
            lastGrant_q <= lastGrant_d;
            s1Valid_q   <= s1Valid_d;
            s1Exp_q     <= s1Exp_d;
            s1Mant_q    <= s1Mant_d;
            s1Tag_q     <= s1Tag_d;
            outValid_q  <= outValid_d;
            outExp_q    <= outExp_d;
            outMant_q   <= outMant_d;
            outTag_q    <= outTag_d;
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.out_exp   = outExp_q;
    assign bus.out_mant  = outMant_q;
    assign bus.out_tag   = outTag_q;
endmodule
